// File: rtl/gray_pkg.sv
// ---------------------------------------------------------------------------
// gray_pkg
// Shared Gray-code helpers for the Gray counter (transmit side) and the
// Gray-to-binary decoder (receive side).
//   GRAY_W_DEF : default count width
//   GRAY_W_MAX : widest supported count; the helpers work on zero-extended
//                values of this width, so any narrower width can use them by
//                truncating the result.
//   bin2gray() : binary -> Gray
//   gray2bin() : Gray -> binary (prefix XOR from the MSB down)
// ---------------------------------------------------------------------------
package gray_pkg;

  localparam int GRAY_W_DEF = 4;
  localparam int GRAY_W_MAX = 16;

  // Zero extension is harmless: the top Gray bit of a narrower value becomes
  // b[W-1] ^ 0 = b[W-1], which is exactly the MSB rule.
  function automatic logic [GRAY_W_MAX-1:0] bin2gray(input logic [GRAY_W_MAX-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [GRAY_W_MAX-1:0] gray2bin(input logic [GRAY_W_MAX-1:0] g);
    logic [GRAY_W_MAX-1:0] b;
    b[GRAY_W_MAX-1] = g[GRAY_W_MAX-1];
    for (int i = GRAY_W_MAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/bin_gray.sv
// ---------------------------------------------------------------------------
// bin_gray
// Pure combinational binary-to-Gray encoder.
// Ports:
//   bin [WIDTH-1:0] in  : binary value
//   gry [WIDTH-1:0] out : Gray code of bin, MSB first
// ---------------------------------------------------------------------------
module bin_gray
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_W_DEF
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gry
);

  assign gry[WIDTH-1] = bin[WIDTH-1];

  for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_xor
    assign gry[gi] = bin[gi+1] ^ bin[gi];
  end

endmodule

// File: rtl/gray_counter.sv
// ---------------------------------------------------------------------------
// gray_counter
// Registered binary up/down counter with a registered Gray-coded copy.
// The Gray value is encoded from the next-state binary and captured on the
// same edge as the binary, so gry and bn never skew and gry has no
// combinational path from any input.
// Ports:
//   clk      in  : rising-edge clock
//   rst_n    in  : asynchronous active-low reset
//   en       in  : count enable, one step per clock
//   up_dn    in  : 1 = increment, 0 = decrement
//   ld       in  : synchronous load strobe (priority over en)
//   ld_bin   in  : binary value loaded when ld = 1
//   gry      out : registered Gray code of the count
//   bn       out : registered binary count
//   wrap     out : one-cycle pulse after a counting wrap (never on load)
//   step_err out : (only with GRAY_STEP_CHK_EN) sticky flag, set when gry
//                  moved by more than one bit across a non-load edge
// Build option: define GRAY_STEP_CHK_EN to add the step checker and port.
// ---------------------------------------------------------------------------
module gray_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_bin,
  output logic [WIDTH-1:0] gry,
  output logic [WIDTH-1:0] bn,
`ifdef GRAY_STEP_CHK_EN
  output logic             wrap,
  output logic             step_err
`else
  output logic             wrap
`endif
);

  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] BIN_MAX = {WIDTH{1'b1}};

  logic [WIDTH-1:0] bn_q, bn_d;
  logic [WIDTH-1:0] gry_q, gry_d;
  logic             wrap_q, wrap_d;

  always_comb begin
    bn_d   = bn_q;
    wrap_d = 1'b0;
    if (ld) begin
      bn_d = ld_bin;
    end else if (en) begin
      if (up_dn) begin
        bn_d   = bn_q + ONE;
        wrap_d = (bn_q == BIN_MAX);
      end else begin
        bn_d   = bn_q - ONE;
        wrap_d = (bn_q == '0);
      end
    end
  end

  // Encode the next state, not the registered count, so both registers
  // load matching values on the same edge.
  bin_gray #(
    .WIDTH(WIDTH)
  ) u_enc (
    .bin(bn_d),
    .gry(gry_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bn_q   <= '0;
      gry_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      bn_q   <= bn_d;
      gry_q  <= gry_d;
      wrap_q <= wrap_d;
    end
  end

  assign bn   = bn_q;
  assign gry  = gry_q;
  assign wrap = wrap_q;

`ifdef GRAY_STEP_CHK_EN
  // prev_gry_q holds gry from before the latest edge; chk_vld_q says that
  // edge was not a load, so (prev_gry_q -> gry_q) is a genuine count step.
  logic [WIDTH-1:0] prev_gry_q, prev_gry_d;
  logic [WIDTH-1:0] step_diff;
  logic             chk_vld_q, chk_vld_d;
  logic             step_err_q, step_err_d;

  always_comb begin
    prev_gry_d = gry_q;
    chk_vld_d  = ~ld;
    step_diff  = gry_q ^ prev_gry_q;
    // x & (x-1) is non-zero exactly when more than one bit of x is set.
    step_err_d = step_err_q | (chk_vld_q & (|(step_diff & (step_diff - ONE))));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_gry_q <= '0;
      chk_vld_q  <= 1'b0;
      step_err_q <= 1'b0;
    end else begin
      prev_gry_q <= prev_gry_d;
      chk_vld_q  <= chk_vld_d;
      step_err_q <= step_err_d;
    end
  end

  assign step_err = step_err_q;
`endif

endmodule

// File: tb/tb_gray_counter.sv
module tb_gray_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  // WIDTH = 4 instance for the directed scenarios
  logic       en, up_dn, ld;
  logic [3:0] ld_bin, gry, bn;
  logic       wrap;
  // WIDTH = 6 instance for the random run
  logic       en6, up6, ld6;
  logic [5:0] ld_bin6, gry6, bn6;
  logic       wrap6;
`ifdef GRAY_STEP_CHK_EN
  logic       step_err, step_err6;
`endif

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  gray_counter #(.WIDTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .ld(ld), .ld_bin(ld_bin),
    .gry(gry), .bn(bn),
`ifdef GRAY_STEP_CHK_EN
    .wrap(wrap), .step_err(step_err)
`else
    .wrap(wrap)
`endif
  );

  gray_counter #(.WIDTH(6)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .en(en6), .up_dn(up6), .ld(ld6), .ld_bin(ld_bin6),
    .gry(gry6), .bn(bn6),
`ifdef GRAY_STEP_CHK_EN
    .wrap(wrap6), .step_err(step_err6)
`else
    .wrap(wrap6)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
    $display("[%0t] w4 bn=%b gry=%b wrap=%b | w6 bn=%b gry=%b wrap=%b",
             $time, bn, gry, wrap, bn6, gry6, wrap6);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en = 0; up_dn = 1; ld = 0; ld_bin = '0;
    en6 = 0; up6 = 1; ld6 = 0; ld_bin6 = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_cnt++;
      if ({bn, gry, wrap} !== 9'b0)
        $display("FAIL reset_state cyc%0d: bn=%b gry=%b wrap=%b expected 0000/0000/0", i, bn, gry, wrap);
      else pass_cnt++;
    end
    rst_n = 1'b1;
  endtask

  task automatic test_up_count;
    logic [3:0] exp_g [0:17] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                                 4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000, 4'b0001};
    logic [3:0] exp_b;
    logic       exp_w;
    en = 1; up_dn = 1;
    chk_cnt++;
    if (gry !== exp_g[0]) $display("FAIL up_start: gry=%b expected %b", gry, exp_g[0]);
    else pass_cnt++;
    for (int i = 1; i <= 17; i++) begin
      tick();
      exp_b = 4'(i);
      exp_w = (i == 16);
      chk_cnt++;
      if ({bn, gry, wrap} !== {exp_b, exp_g[i], exp_w})
        $display("FAIL up_count step%0d: bn=%b gry=%b wrap=%b expected %b/%b/%b",
                 i, bn, gry, wrap, exp_b, exp_g[i], exp_w);
      else pass_cnt++;
    end
    en = 0;
  endtask

  task automatic test_down_wrap;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    en = 1; up_dn = 0;
    tick();
    chk_cnt++;
    if ({bn, gry, wrap} !== {4'b1111, 4'b1000, 1'b1})
      $display("FAIL down_wrap: bn=%b gry=%b wrap=%b expected 1111/1000/1", bn, gry, wrap);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if ({bn, gry, wrap} !== {4'b1110, 4'b1001, 1'b0})
      $display("FAIL down_after_wrap: bn=%b gry=%b wrap=%b expected 1110/1001/0", bn, gry, wrap);
    else pass_cnt++;
    en = 0;
  endtask

  task automatic test_load_priority;
    ld = 1; ld_bin = 4'b1001; en = 1; up_dn = 1;
    tick();
    chk_cnt++;
    if ({bn, gry, wrap} !== {4'b1001, 4'b1101, 1'b0})
      $display("FAIL load_over_en: bn=%b gry=%b wrap=%b expected 1001/1101/0", bn, gry, wrap);
    else pass_cnt++;
    ld_bin = 4'b1111;
    tick();
    chk_cnt++;
    if ({bn, gry, wrap} !== {4'b1111, 4'b1000, 1'b0})
      $display("FAIL load_max: bn=%b gry=%b wrap=%b expected 1111/1000/0", bn, gry, wrap);
    else pass_cnt++;
    ld_bin = 4'b0000;
    tick();
    chk_cnt++;
    if ({bn, gry, wrap} !== {4'b0000, 4'b0000, 1'b0})
      $display("FAIL load_zero_from_max: bn=%b gry=%b wrap=%b expected 0000/0000/0", bn, gry, wrap);
    else pass_cnt++;
    ld = 0; en = 0;
  endtask

  task automatic test_hold_dir;
    logic [3:0] prev_g;
    ld = 1; ld_bin = 4'b0011;
    tick();
    ld = 0; en = 1; up_dn = 1;
    tick();
    tick();
    chk_cnt++;
    if ({bn, gry} !== {4'b0101, 4'b0111})
      $display("FAIL hold_setup: bn=%b gry=%b expected 0101/0111", bn, gry);
    else pass_cnt++;
    en = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_cnt++;
      if ({bn, gry, wrap} !== {4'b0101, 4'b0111, 1'b0})
        $display("FAIL hold cyc%0d: bn=%b gry=%b wrap=%b expected 0101/0111/0", i, bn, gry, wrap);
      else pass_cnt++;
    end
    prev_g = gry;
    en = 1; up_dn = 1;
    tick();
    chk_cnt++;
    if ({bn, gry, wrap} !== {4'b0110, 4'b0101, 1'b0} || $countones(gry ^ prev_g) != 1)
      $display("FAIL dir_up: bn=%b gry=%b wrap=%b expected 0110/0101/0 one-bit step", bn, gry, wrap);
    else pass_cnt++;
    prev_g = gry;
    up_dn = 0;
    tick();
    chk_cnt++;
    if ({bn, gry, wrap} !== {4'b0101, 4'b0111, 1'b0} || $countones(gry ^ prev_g) != 1)
      $display("FAIL dir_down: bn=%b gry=%b wrap=%b expected 0101/0111/0 one-bit step", bn, gry, wrap);
    else pass_cnt++;
    en = 0;
  endtask

  task automatic test_async_reset;
    ld = 1; ld_bin = 4'b1001;
    tick();
    ld = 0; en = 1; up_dn = 1;
    tick();
    chk_cnt++;
    if ({bn, gry} !== {4'b1010, 4'b1111})
      $display("FAIL areset_setup: bn=%b gry=%b expected 1010/1111", bn, gry);
    else pass_cnt++;
    #2;
    rst_n = 1'b0;  // mid-cycle, well away from any clock edge
    #1;
    chk_cnt++;
    if ({bn, gry, wrap} !== 9'b0)
      $display("FAIL areset_immediate: bn=%b gry=%b wrap=%b expected 0000/0000/0", bn, gry, wrap);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if ({bn, gry, wrap} !== 9'b0)
      $display("FAIL areset_held: bn=%b gry=%b wrap=%b expected 0000/0000/0", bn, gry, wrap);
    else pass_cnt++;
    rst_n = 1'b1;
    tick();
    chk_cnt++;
    if ({bn, gry, wrap} !== {4'b0001, 4'b0001, 1'b0})
      $display("FAIL areset_resume: bn=%b gry=%b wrap=%b expected 0001/0001/0", bn, gry, wrap);
    else pass_cnt++;
    en = 0;
  endtask

  task automatic test_random_w6;
    logic [5:0] bn_m, exp_g;
    logic       wrap_m;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bn_m = '0;
    for (int i = 0; i < 200; i++) begin
      en6     = ($urandom_range(9, 0) < 7);
      up6     = $urandom_range(1, 0) != 0;
      ld6     = ($urandom_range(9, 0) == 0);
      ld_bin6 = 6'($urandom_range(63, 0));
      wrap_m  = 1'b0;
      if (ld6) begin
        bn_m = ld_bin6;
      end else if (en6) begin
        if (up6) begin
          wrap_m = (bn_m == 6'd63);
          bn_m   = bn_m + 6'd1;
        end else begin
          wrap_m = (bn_m == 6'd0);
          bn_m   = bn_m - 6'd1;
        end
      end
      exp_g = bn_m ^ (bn_m >> 1);
      tick();
      chk_cnt++;
      if ({bn6, gry6, wrap6} !== {bn_m, exp_g, wrap_m})
        $display("FAIL rand_w6 cyc%0d: bn=%b gry=%b wrap=%b expected %b/%b/%b",
                 i, bn6, gry6, wrap6, bn_m, exp_g, wrap_m);
      else pass_cnt++;
`ifdef GRAY_STEP_CHK_EN
      chk_cnt++;
      if (step_err6 !== 1'b0)
        $display("FAIL step_err cyc%0d: step_err=%b expected 0", i, step_err6);
      else pass_cnt++;
`endif
    end
    en6 = 0; ld6 = 0;
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_down_wrap();
    test_load_priority();
    test_hold_dir();
    test_async_reset();
    test_random_w6();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/gray_counter.md
Name: gray_counter

Overview:
- Registered binary-to-Gray up/down counter. It is the transmit-side counterpart of the team's Gray-to-binary decoder.
- Holds a binary count and drives a glitch-free, registered Gray-coded version of it.
- Feeds Gray-coded pointers/positions across clock domains and to encoder-based position interfaces.
- Supports synchronous load, hold, direction control and a wrap indication.

Parameters:
- WIDTH, 4, bit width of the count and of the Gray output (legal range 2..16).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  count enable; one step per clock while high
- up_dn  input  1  direction: 1 = increment, 0 = decrement
- ld  input  1  synchronous load strobe
- ld_bin  input  WIDTH  binary value loaded when ld=1
- gry  output  WIDTH  registered Gray code of the current count, MSB first
- bn  output  WIDTH  registered binary count
- wrap  output  1  one-cycle pulse after the count wraps

Behaviour:
- Interface: single clock clk; reset rst_n is asynchronous and active-low.
- Reset (rst_n=0, asynchronous): bn=0, gry=0, wrap=0. Outputs stay at these values while rst_n is low.
- Reset release: first count/load is taken on the first rising clk edge with rst_n high.
- Per rising edge, priority ld > en > hold:
  - ld=1: bn <= ld_bin; gry <= bin2gray(ld_bin); wrap <= 0. ld wins over en regardless of up_dn.
  - ld=0, en=1, up_dn=1: bn <= bn+1, modulo 2^WIDTH.
  - ld=0, en=1, up_dn=0: bn <= bn-1, modulo 2^WIDTH.
  - ld=0, en=0: bn and gry hold; wrap <= 0.
- Gray encoding: gry[WIDTH-1] = bn[WIDTH-1]; gry[i] = bn[i+1] ^ bn[i] for i < WIDTH-1.
- Latency and registering:
  - gry is computed from the next-state binary and registered in the same edge as bn.
  - Invariant: gry == bin2gray(bn) on every cycle. There is zero-cycle skew between the two outputs.
  - No combinational path from any input to gry; gry must not be decoded from bn combinationally after the register.
- Wrap:
  - wrap=1 for exactly one cycle following an edge where an up count went from 2^WIDTH-1 to 0, or a down count went from 0 to 2^WIDTH-1.
  - Otherwise wrap=0.
  - Loading max or 0 does not assert wrap.
- Single-step property: in consecutive cycles with ld=0, gry changes in exactly one bit (en=1) or zero bits (en=0). This includes the wrap step.
- Direction change mid-run: takes effect on the same edge. Sequence 5 up-> 6, then down-> 5 is legal.
- Reset mid-operation: asynchronous clear overrides any in-progress ld/en. No pending state survives reset.

Optional Feature:
- Macro: GRAY_STEP_CHK_EN
- Defined:
  - Adds output step_err (1 bit, reset 0).
  - Internal register holds the previous gry plus a "check valid" flag.
  - The flag is cleared by reset and by ld, and set after any non-load edge.
  - When the flag is set, step_err is set sticky if popcount(gry ^ prev_gry) > 1.
  - step_err clears only on rst_n.
- Undefined: no step_err port and no checker logic; port list is exactly as above.

Decomposition:
- Shared package gray_pkg:
  - localparam GRAY_W_DEF = 4.
  - function bin2gray(input [WIDTH-1:0]).
  - function gray2bin, for bench reference and reuse by the decoder.
- One sub-module is natural: bin_gray, a pure combinational binary-to-Gray encoder parameterised by WIDTH.
  - gray_counter instantiates it on the next-state binary.
  - Benches reuse it as the reference model.

Test Plan:
1. Reset then up count, WIDTH=4: rst_n low 3 cycles, then en=1, up_dn=1 for 17 cycles. Required:
   - gry sequence 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, 0000.
   - wrap=1 only in the cycle where bn returns to 0.
2. Down wrap: from reset, en=1, up_dn=0 for 1 cycle. Required: bn=1111, gry=1000, wrap=1 for one cycle; next down step gives bn=1110, gry=1001, wrap=0.
3. Load priority: ld=1, ld_bin=1001, en=1, up_dn=1. Required: next cycle bn=1001, gry=1101, wrap=0. ld with ld_bin=1111 also gives wrap=0.
4. Hold and direction change: count to bn=0101 (gry 0111), en=0 for 4 cycles, then up one, then down one. Required:
   - bn/gry frozen at 0101/0111 during hold.
   - Then 0110/0101, then 0101/0111.
   - Exactly one gry bit changes per step.
5. Asynchronous reset mid-run: at bn=1010, drop rst_n between clock edges. Required: bn, gry and wrap go to 0 immediately without waiting for clk; after release, counting resumes from 0000.
6. With GRAY_STEP_CHK_EN defined:
   - 200 cycles of random en/up_dn/ld, WIDTH=6. Required: step_err stays 0 throughout; gry == bin2gray(bn) every cycle.
   - Compile without the macro. Required: no step_err port.
